// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control FSM: state encodings,
// opcode/funct constants, ALU op codes, mux select encodings and the
// control word that the output decoder produces.
package mips_ctrl_pkg;

    // FSM state encodings; code 4'd15 is unused and recovers to FETCH
    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXEC    = 4'd6,
        ALUWB   = 4'd7,
        ADDIEX  = 4'd8,
        ANDIEX  = 4'd9,
        IMMWB   = 4'd10,
        BRANCH  = 4'd11,
        JAL     = 4'd12,
        JR      = 4'd13,
        ILLEGAL = 4'd14
    } stateT;

    // Opcodes understood by the controller
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    // funct code that turns an R-type into jr
    localparam logic [5:0] FUNCT_JR = 6'b001000;

    // ALU operation codes
    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b100;
    localparam logic [2:0] ALU_ADDI  = 3'b101;

    // Write register select
    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    // Writeback data select
    localparam logic [1:0] WB_ALUOUT = 2'b00;
    localparam logic [1:0] WB_MDR    = 2'b01;
    localparam logic [1:0] WB_PC     = 2'b10;

    // ALU B operand select
    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_REGA   = 2'b11;

    // Complete set of datapath controls for one cycle
    typedef struct packed {
        logic       pcWrite;
        logic       pcWriteCond;
        logic       iord;
        logic       memRead;
        logic       memWrite;
        logic       irWrite;
        logic [1:0] regDst;
        logic [1:0] memToReg;
        logic       regWrite;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [2:0] aluOp;
        logic [1:0] pcSource;
        logic       illegalOp;
    } ctrlWordT;

    // Control word with every field deasserted
    function automatic ctrlWordT ctrlIdle();
        ctrlWordT w;
        w = '0;
        return w;
    endfunction

    // True for the two load/store opcodes that share the MEMADR step
    function automatic logic isMemOp(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/multicycle_control_fsm_decode.sv
// Moore output decoder: maps the current state (plus mem_ready, which only
// qualifies the FETCH-cycle PC and IR loads) to the datapath control word.
module mc_output_decode
    import mips_ctrl_pkg::*;
(
    input  stateT    state,
    input  logic     memReady,
    output ctrlWordT ctrl
);

    // Per-state control word; anything not named for a state stays 0
    always_comb begin
        ctrl = ctrlIdle();
        case (state)
            FETCH: begin
                ctrl.memRead  = 1'b1;
                ctrl.iord     = 1'b0;
                ctrl.aluSrcA  = 1'b0;
                ctrl.aluSrcB  = SRCB_FOUR;
                ctrl.aluOp    = ALU_ADD;
                ctrl.pcSource = PCSRC_ALU;
                // PC+4 and IR are only captured once the read completes
                if (memReady) begin
                    ctrl.irWrite = 1'b1;
                    ctrl.pcWrite = 1'b1;
                end else begin
                    ctrl.irWrite = 1'b0;
                    ctrl.pcWrite = 1'b0;
                end
            end
            DECODE: begin
                // Branch target precomputed speculatively into ALUOut
                ctrl.aluSrcA = 1'b0;
                ctrl.aluSrcB = SRCB_IMMSH2;
                ctrl.aluOp   = ALU_ADD;
            end
            MEMADR: begin
                ctrl.aluSrcA = 1'b1;
                ctrl.aluSrcB = SRCB_IMM;
                ctrl.aluOp   = ALU_ADD;
            end
            MEMRD: begin
                ctrl.memRead = 1'b1;
                ctrl.iord    = 1'b1;
            end
            MEMWB: begin
                ctrl.regWrite = 1'b1;
                ctrl.regDst   = REGDST_RT;
                ctrl.memToReg = WB_MDR;
            end
            MEMWR: begin
                ctrl.memWrite = 1'b1;
                ctrl.iord     = 1'b1;
            end
            EXEC: begin
                ctrl.aluSrcA = 1'b1;
                ctrl.aluSrcB = SRCB_REG;
                ctrl.aluOp   = ALU_FUNCT;
            end
            ALUWB: begin
                ctrl.regWrite = 1'b1;
                ctrl.regDst   = REGDST_RD;
                ctrl.memToReg = WB_ALUOUT;
            end
            ADDIEX: begin
                ctrl.aluSrcA = 1'b1;
                ctrl.aluSrcB = SRCB_IMM;
                ctrl.aluOp   = ALU_ADDI;
            end
            ANDIEX: begin
                ctrl.aluSrcA = 1'b1;
                ctrl.aluSrcB = SRCB_IMM;
                ctrl.aluOp   = ALU_AND;
            end
            IMMWB: begin
                ctrl.regWrite = 1'b1;
                ctrl.regDst   = REGDST_RT;
                ctrl.memToReg = WB_ALUOUT;
            end
            BRANCH: begin
                ctrl.aluSrcA     = 1'b1;
                ctrl.aluSrcB     = SRCB_REG;
                ctrl.aluOp       = ALU_SUB;
                ctrl.pcWriteCond = 1'b1;
                ctrl.pcSource    = PCSRC_ALUOUT;
            end
            JAL: begin
                // $31 takes the already-incremented PC in the same edge the PC jumps
                ctrl.regWrite = 1'b1;
                ctrl.regDst   = REGDST_RA;
                ctrl.memToReg = WB_PC;
                ctrl.pcWrite  = 1'b1;
                ctrl.pcSource = PCSRC_JUMP;
            end
            JR: begin
                ctrl.pcWrite  = 1'b1;
                ctrl.pcSource = PCSRC_REGA;
            end
            ILLEGAL: begin
                ctrl.illegalOp = 1'b1;
            end
            default: begin
                ctrl = ctrlIdle();
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS sequencing controller. Holds the state register and the
// next-state logic; control outputs come from mc_output_decode and are forced
// low while reset is asserted.
module multicycle_control_fsm
    import mips_ctrl_pkg::*;
#(
    parameter int          STATE_W  = 4,
    parameter logic [5:0]  JR_FUNCT = FUNCT_JR
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               iord,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic [1:0]         reg_dst,
    output logic [1:0]         mem_to_reg,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [2:0]         alu_op,
    output logic [1:0]         pc_source,
    output logic [STATE_W-1:0] state_out,
    output logic               illegal_op
);

    logic [STATE_W-1:0] stateReg;
    stateT              stateCur;
    stateT              stateNext;
    ctrlWordT           ctrlDecoded;
    ctrlWordT           ctrlOut;

    // Only the low four bits ever carry an encoding; upper bits load as zero
    assign stateCur = stateT'(stateReg[3:0]);

    // Next-state selection; opcode is only consulted in DECODE and MEMADR
    always_comb begin
        stateNext = FETCH;
        case (stateCur)
            FETCH: begin
                if (mem_ready) begin
                    stateNext = DECODE;
                end else begin
                    stateNext = FETCH;
                end
            end
            DECODE: begin
                case (opcode)
                    OP_RTYPE: begin
                        if (funct == JR_FUNCT) begin
                            stateNext = JR;
                        end else begin
                            stateNext = EXEC;
                        end
                    end
                    OP_LW, OP_SW: stateNext = MEMADR;
                    OP_ADDI:      stateNext = ADDIEX;
                    OP_ANDI:      stateNext = ANDIEX;
                    OP_BEQ:       stateNext = BRANCH;
                    OP_JAL:       stateNext = JAL;
                    default:      stateNext = ILLEGAL;
                endcase
            end
            MEMADR: begin
                // An opcode that stopped being a load/store since DECODE is a fault
                if (!isMemOp(opcode)) begin
                    stateNext = ILLEGAL;
                end else if (opcode == OP_LW) begin
                    stateNext = MEMRD;
                end else begin
                    stateNext = MEMWR;
                end
            end
            MEMRD: begin
                if (mem_ready) begin
                    stateNext = MEMWB;
                end else begin
                    stateNext = MEMRD;
                end
            end
            MEMWR: begin
                if (mem_ready) begin
                    stateNext = FETCH;
                end else begin
                    stateNext = MEMWR;
                end
            end
            MEMWB:   stateNext = FETCH;
            EXEC:    stateNext = ALUWB;
            ALUWB:   stateNext = FETCH;
            ADDIEX:  stateNext = IMMWB;
            ANDIEX:  stateNext = IMMWB;
            IMMWB:   stateNext = FETCH;
            BRANCH:  stateNext = FETCH;
            JAL:     stateNext = FETCH;
            JR:      stateNext = FETCH;
            // Sticky trap: only reset leaves it
            ILLEGAL: stateNext = ILLEGAL;
            default: stateNext = FETCH;
        endcase
    end

    // State register with synchronous reset into FETCH
    always_ff @(posedge clk) begin
        if (rst) begin
            stateReg <= STATE_W'(FETCH);
        end else begin
            stateReg <= STATE_W'(stateNext);
        end
    end

    mc_output_decode uDecode (
        .state    (stateCur),
        .memReady (mem_ready),
        .ctrl     (ctrlDecoded)
    );

    // Hold every output low for as long as reset is asserted
    always_comb begin
        if (rst) begin
            ctrlOut   = ctrlIdle();
            state_out = '0;
        end else begin
            ctrlOut   = ctrlDecoded;
            state_out = stateReg;
        end
    end

    assign pc_write      = ctrlOut.pcWrite;
    assign pc_write_cond = ctrlOut.pcWriteCond;
    assign iord          = ctrlOut.iord;
    assign mem_read      = ctrlOut.memRead;
    assign mem_write     = ctrlOut.memWrite;
    assign ir_write      = ctrlOut.irWrite;
    assign reg_dst       = ctrlOut.regDst;
    assign mem_to_reg    = ctrlOut.memToReg;
    assign reg_write     = ctrlOut.regWrite;
    assign alu_src_a     = ctrlOut.aluSrcA;
    assign alu_src_b     = ctrlOut.aluSrcB;
    assign alu_op        = ctrlOut.aluOp;
    assign pc_source     = ctrlOut.pcSource;
    assign illegal_op    = ctrlOut.illegalOp;

endmodule
